// File: rtl/row_reg_loader.sv
// Row register loader: queues conv_row segment descriptors and expands each into
// west-pad zeros, row-buffer pixel copies (1-cycle read latency) and east-pad zeros.
module row_reg_loader #(
    parameter int DATA_W        = 8,
    parameter int PIXELS_IN_ROW = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              desc_valid,
    input  logic [15:0]       row_idx,
    input  logic [15:0]       row_start_idx,
    input  logic [15:0]       reg_start_idx,
    input  logic [15:0]       reg_end_idx,
    input  logic [3:0]        west_pad,
    input  logic [3:0]        slab_num,
    input  logic [3:0]        east_pad,
    input  logic              desc_last,
    output logic              fifo_full,
    output logic              buf_rd_en,
    output logic [15:0]       buf_rd_row,
    output logic [15:0]       buf_rd_col,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              reg_wr_en,
    output logic [15:0]       reg_wr_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              row_done,
    output logic              busy,
    output logic              overflow_err,
    output logic              desc_err
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int DESC_W = 77;
    localparam int CNT_W  = $clog2(PIXELS_IN_ROW + 1);
    localparam logic signed [17:0] N_MAX = PIXELS_IN_ROW;

    typedef enum logic [2:0] {IDLE, WEST, DATA, DRAIN, EAST} state_t;

    logic [DESC_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              push_ok, pop, malformed;
    logic [DESC_W-1:0] head;

    logic [15:0] h_row, h_col, h_rs, h_re;
    logic [3:0]  h_west, h_slab, h_east;
    logic        h_last;
    logic signed [17:0] n_calc, w0_calc;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  n_reg;
    logic [15:0]       row_reg, col_reg, rs_reg, w0_reg, dwr_addr_reg;
    logic [3:0]        west_reg, east_reg;
    logic              last_reg, dwr_reg;
    logic              overflow_err_reg, desc_err_reg;

    assign fifo_full = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is always lost.
    assign push_ok   = desc_valid && !fifo_full;
    assign pop       = (state_reg == IDLE) && (count_reg != '0);
    assign head      = fifo_mem[rd_ptr_reg];

    assign {h_last, h_east, h_slab, h_west, h_re, h_rs, h_col, h_row} = head;

    assign n_calc    = $signed({2'b00, h_re}) - $signed({2'b00, h_rs}) + 18'sd1
                       - $signed({14'b0, h_east});
    assign w0_calc   = $signed({2'b00, h_rs}) - $signed({14'b0, h_slab})
                       - $signed({14'b0, h_west});
    assign malformed = (n_calc < 18'sd1) || (n_calc > N_MAX) || (w0_calc < 18'sd0);

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= {desc_last, east_pad, slab_num, west_pad,
                                     reg_end_idx, reg_start_idx, row_start_idx, row_idx};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            n_reg            <= '0;
            row_reg          <= '0;
            col_reg          <= '0;
            rs_reg           <= '0;
            w0_reg           <= '0;
            west_reg         <= '0;
            east_reg         <= '0;
            last_reg         <= 1'b0;
            dwr_reg          <= 1'b0;
            dwr_addr_reg     <= '0;
            overflow_err_reg <= 1'b0;
            desc_err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (pop && !malformed) begin
                n_reg    <= n_calc[CNT_W-1:0];
                row_reg  <= h_row;
                col_reg  <= h_col;
                rs_reg   <= h_rs;
                w0_reg   <= w0_calc[15:0];
                west_reg <= h_west;
                east_reg <= h_east;
                last_reg <= h_last;
            end
            // Each DATA read lands one cycle later at the matching register address.
            dwr_reg      <= (state_reg == DATA);
            dwr_addr_reg <= rs_reg + 16'(cnt_reg);
            if (desc_valid && fifo_full)
                overflow_err_reg <= 1'b1;
            if (pop && malformed)
                desc_err_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (pop && !malformed)
                    state_next = (h_west != 4'd0) ? WEST : DATA;
            end
            WEST: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg + CNT_W'(1) == CNT_W'(west_reg)) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end
            end
            DATA: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg + CNT_W'(1) == n_reg) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end
            end
            DRAIN: begin
                cnt_next   = '0;
                state_next = (east_reg != 4'd0) ? EAST : IDLE;
            end
            EAST: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg + CNT_W'(1) == CNT_W'(east_reg)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        buf_rd_en   = 1'b0;
        buf_rd_row  = '0;
        buf_rd_col  = '0;
        reg_wr_en   = 1'b0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        row_done    = 1'b0;
        case (state_reg)
            WEST: begin
                reg_wr_en   = 1'b1;
                reg_wr_addr = w0_reg + 16'(cnt_reg);
            end
            DATA: begin
                buf_rd_en  = 1'b1;
                buf_rd_row = row_reg;
                buf_rd_col = col_reg + 16'(cnt_reg);
            end
            DRAIN: row_done = last_reg && (east_reg == 4'd0);
            EAST: begin
                reg_wr_en   = 1'b1;
                reg_wr_addr = rs_reg + 16'(n_reg) + 16'(cnt_reg);
                row_done    = last_reg && (cnt_reg + CNT_W'(1) == CNT_W'(east_reg));
            end
            default: ;
        endcase
        if (dwr_reg) begin
            reg_wr_en   = 1'b1;
            reg_wr_addr = dwr_addr_reg;
            reg_wr_data = buf_rd_data;
        end
    end

    assign busy         = (state_reg != IDLE) || (count_reg != '0);
    assign overflow_err = overflow_err_reg;
    assign desc_err     = desc_err_reg;
endmodule

// File: tb/tb_row_reg_loader.sv
// Bench for row_reg_loader: directed scenarios plus random descriptor bursts checked
// against an expected write/read stream built from the descriptor rules.
module tb_row_reg_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        desc_valid = 1'b0;
    logic [15:0] row_idx = '0, row_start_idx = '0, reg_start_idx = '0, reg_end_idx = '0;
    logic [3:0]  west_pad = '0, slab_num = '0, east_pad = '0;
    logic        desc_last = 1'b0;
    logic        fifo_full, buf_rd_en, reg_wr_en, row_done, busy, overflow_err, desc_err;
    logic [15:0] buf_rd_row, buf_rd_col, reg_wr_addr;
    logic [7:0]  buf_rd_data = '0;
    logic [7:0]  reg_wr_data;

    int tests = 0, fails = 0, cyc = 0, stray_done = 0;
    int push_c, idle_c, n0;

    logic [15:0] wa_q[$], rr_q[$], rc_q[$], ea_q[$], er_q[$], ec_q[$];
    logic [7:0]  wd_q[$], ed_q[$];
    logic        wn_q[$], en_q[$];
    int          wc_q[$], rcyc_q[$];

    row_reg_loader #(.DATA_W(8), .PIXELS_IN_ROW(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .desc_valid(desc_valid), .row_idx(row_idx),
        .row_start_idx(row_start_idx), .reg_start_idx(reg_start_idx), .reg_end_idx(reg_end_idx),
        .west_pad(west_pad), .slab_num(slab_num), .east_pad(east_pad), .desc_last(desc_last),
        .fifo_full(fifo_full), .buf_rd_en(buf_rd_en), .buf_rd_row(buf_rd_row),
        .buf_rd_col(buf_rd_col), .buf_rd_data(buf_rd_data), .reg_wr_en(reg_wr_en),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .row_done(row_done),
        .busy(busy), .overflow_err(overflow_err), .desc_err(desc_err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix(input logic [15:0] r, input logic [15:0] c);
        return (r[7:0] * 8'd29) ^ (c[7:0] + c[15:8] + 8'h5a);
    endfunction

    // Row buffer: data for the address read last cycle, garbage otherwise.
    always @(posedge clk) buf_rd_data <= buf_rd_en ? pix(buf_rd_row, buf_rd_col) : 8'($urandom);

    always @(negedge clk) begin
        if (!reset) begin
            if (reg_wr_en) begin
                wa_q.push_back(reg_wr_addr);
                wd_q.push_back(reg_wr_data);
                wn_q.push_back(row_done);
                wc_q.push_back(cyc);
            end else if (row_done) begin
                stray_done++;
            end
            if (buf_rd_en) begin
                rr_q.push_back(buf_rd_row);
                rc_q.push_back(buf_rd_col);
                rcyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] outs();
        return {1'b0, fifo_full, buf_rd_en, buf_rd_row, buf_rd_col, reg_wr_en, reg_wr_addr,
                reg_wr_data, row_done, busy, overflow_err, desc_err};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected effect of one accepted descriptor, straight from the segment rules.
    task automatic model_desc(input logic [15:0] r, c, rs, re, input logic [3:0] w, s, e,
                              input logic l);
        int n, w0;
        n  = int'(re) - int'(rs) + 1 - int'(e);
        w0 = int'(rs) - int'(s) - int'(w);
        if (n < 1 || n > 32 || w0 < 0) return;
        for (int i = 0; i < int'(w); i++) begin
            ea_q.push_back(16'(w0 + i)); ed_q.push_back(8'h00); en_q.push_back(1'b0);
        end
        for (int j = 0; j < n; j++) begin
            er_q.push_back(r); ec_q.push_back(16'(int'(c) + j));
            ea_q.push_back(16'(int'(rs) + j)); ed_q.push_back(pix(r, 16'(int'(c) + j)));
            en_q.push_back(1'b0);
        end
        for (int i = 0; i < int'(e); i++) begin
            ea_q.push_back(16'(int'(rs) + n + i)); ed_q.push_back(8'h00); en_q.push_back(1'b0);
        end
        if (l) en_q[en_q.size()-1] = 1'b1;
    endtask

    task automatic send(input logic [15:0] r, c, rs, re, input logic [3:0] w, s, e,
                        input logic l, input bit accept);
        row_idx = r; row_start_idx = c; reg_start_idx = rs; reg_end_idx = re;
        west_pad = w; slab_num = s; east_pad = e; desc_last = l; desc_valid = 1'b1;
        push_c = cyc;
        if (accept) model_desc(r, c, rs, re, w, s, e, l);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy !== 1'b0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
        idle_c = cyc;
    endtask

    task automatic clear_all();
        wa_q.delete(); wd_q.delete(); wn_q.delete(); wc_q.delete();
        rr_q.delete(); rc_q.delete(); rcyc_q.delete();
        ea_q.delete(); ed_q.delete(); en_q.delete(); er_q.delete(); ec_q.delete();
    endtask

    task automatic check_stream(input string tag);
        int m;
        chk({tag, "_nwr"}, 64'(wa_q.size()), 64'(ea_q.size()));
        m = (wa_q.size() < ea_q.size()) ? wa_q.size() : ea_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_wa%0d", tag, i), 64'(wa_q[i]), 64'(ea_q[i]));
            chk($sformatf("%s_wd%0d", tag, i), 64'(wd_q[i]), 64'(ed_q[i]));
            chk($sformatf("%s_dn%0d", tag, i), 64'(wn_q[i]), 64'(en_q[i]));
        end
        chk({tag, "_nrd"}, 64'(rc_q.size()), 64'(ec_q.size()));
        m = (rc_q.size() < ec_q.size()) ? rc_q.size() : ec_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_rd%0d", tag, i), {32'(rr_q[i]), 32'(rc_q[i])},
                {32'(er_q[i]), 32'(ec_q[i])});
    endtask

    initial begin
        int nb, n, kind;
        logic [15:0] r, c, rs, re;
        logic [3:0]  w, s, e;

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // West pad + slab, full-width segment
        clear_all();
        send(16'd5, 16'd0, 16'd4, 16'd35, 4'd2, 4'd1, 4'd0, 1'b0, 1);
        desc_valid = 1'b0;
        wait_idle(100);
        check_stream("west");
        if (wc_q.size() > 0) begin
            chk("west_first_wr_cyc", 64'(wc_q[0]), 64'(push_c + 2));
            chk("west_last_wr_cyc", 64'(wc_q[wc_q.size()-1]), 64'(push_c + 36));
        end
        chk("west_idle_cyc", 64'(idle_c), 64'(push_c + 37));

        // East pad with last segment
        clear_all();
        send(16'd5, 16'd32, 16'd36, 16'd47, 4'd0, 4'd0, 4'd2, 1'b1, 1);
        desc_valid = 1'b0;
        wait_idle(100);
        check_stream("east");
        if (rcyc_q.size() > 0) chk("east_first_rd_cyc", 64'(rcyc_q[0]), 64'(push_c + 2));
        if (wc_q.size() > 0) chk("east_first_wr_cyc", 64'(wc_q[0]), 64'(push_c + 3));
        chk("east_idle_cyc", 64'(idle_c), 64'(push_c + 15));
        chk("desc_err_clean", 64'(desc_err), 64'd0);

        // Malformed descriptors (N=-1, W0<0, N>32) interleaved with valid ones
        clear_all();
        send(16'd7, 16'd0, 16'd10, 16'd11, 4'd0, 4'd0, 4'd3, 1'b0, 1);
        chk("desc_err_not_yet", 64'(desc_err), 64'd0);
        send(16'd7, 16'd3, 16'd20, 16'd23, 4'd1, 4'd0, 4'd0, 1'b1, 1);
        chk("desc_err_set", 64'(desc_err), 64'd1);
        send(16'd8, 16'd0, 16'd1, 16'd4, 4'd1, 4'd1, 4'd0, 1'b0, 1);
        send(16'd8, 16'd0, 16'd0, 16'd32, 4'd0, 4'd0, 4'd0, 1'b0, 1);
        send(16'd8, 16'd9, 16'd3, 16'd5, 4'd2, 4'd1, 4'd1, 1'b1, 1);
        desc_valid = 1'b0;
        wait_idle(200);
        check_stream("malformed");
        chk("overflow_clean", 64'(overflow_err), 64'd0);

        // Six back-to-back pushes from idle: one is dropped
        clear_all();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("ovf_full_k%0d", k), 64'(fifo_full), 64'(k == 5));
            send(16'(20 + k), 16'(k * 4), 16'(100 + k * 8), 16'(107 + k * 8),
                 4'd0, 4'd0, 4'd0, 1'b1, k < 5);
        end
        desc_valid = 1'b0;
        chk("overflow_set", 64'(overflow_err), 64'd1);
        wait_idle(300);
        check_stream("overflow");

        // Random bursts of up to three descriptors
        clear_all();
        for (int b = 0; b < 14; b++) begin
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                n = $urandom_range(1, 32);
                w = 4'($urandom_range(0, 3));
                s = 4'($urandom_range(0, 2));
                e = 4'($urandom_range(0, 3));
                r = 16'($urandom);
                c = 16'($urandom);
                rs = 16'($urandom_range(8, 1000));
                kind = $urandom_range(0, 7);
                if (kind == 0) rs = 16'(int'(s) + int'(w));
                if (kind == 1) rs = 16'hFFF0;
                re = 16'(int'(rs) + n - 1 + int'(e));
                if (kind == 2) re = 16'(int'(rs) + int'(e) - 2);
                if (kind == 3) re = 16'(int'(rs) + 32 + int'(e));
                send(r, c, rs, re, w, s, e, 1'($urandom), 1);
            end
            desc_valid = 1'b0;
            wait_idle(400);
        end
        check_stream("random");
        chk("no_stray_row_done", 64'(stray_done), 64'd0);
        chk("sticky_overflow", 64'(overflow_err), 64'd1);
        chk("sticky_desc_err", 64'(desc_err), 64'd1);

        // Reset in the 10th DATA cycle aborts the descriptor
        clear_all();
        send(16'd9, 16'd0, 16'd50, 16'd69, 4'd0, 4'd0, 4'd0, 1'b1, 1);
        desc_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_outputs", outs(), 64'd0);
        n0 = wa_q.size();
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_no_writes", 64'(wa_q.size()), 64'(n0));
        chk("post_reset_outputs", outs(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
